alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 169 ++++++++++++++++
 tb/tb_alu_issue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: two-entry issue buffer between decode and the ALU.
// A main entry drives the ALU-side outputs and a skid entry absorbs one extra
// instruction under backpressure. Register operands are resolved from the
// writeback bus at capture and refreshed from it every cycle while held.
module alu_issue #(
    parameter int XLEN = 64,
    parameter int AOPW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AOPW-1:0] in_op,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic [4:0]      in_rs1_idx,
    input  logic [4:0]      in_rs2_idx,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operator_1,
    output logic [XLEN-1:0] operator_2,
    output logic [AOPW-1:0] alu_op,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One held instruction. srcNReg/srcNIdx remember where each operand came
    // from so later writebacks can still refresh it.
    typedef struct packed {
        logic [AOPW-1:0] op;
        logic [4:0]      rd;
        logic            rdWen;
        logic [XLEN-1:0] opnd1;
        logic [XLEN-1:0] opnd2;
        logic            src1Reg;
        logic [4:0]      src1Idx;
        logic            src2Reg;
        logic [4:0]      src2Idx;
    } entry_t;

    state_t state, stateNext;
    entry_t mainEntry, skidEntry;
    entry_t mainNext, skidNext;
    entry_t newEntry, mainByp, skidByp;
    logic   inFire, outFire;

    // x0 is hardwired zero, so a writeback naming it never forwards.
    function automatic logic wbHit(logic isReg, logic [4:0] idx,
                                   logic wen, logic [4:0] rd);
        return isReg && (idx != 5'd0) && wen && (idx == rd);
    endfunction

    function automatic entry_t applyBypass(entry_t e, logic wen,
                                           logic [4:0] rd, logic [XLEN-1:0] data);
        entry_t r;
        r = e;
        if (wbHit(e.src1Reg, e.src1Idx, wen, rd)) r.opnd1 = data;
        if (wbHit(e.src2Reg, e.src2Idx, wen, rd)) r.opnd2 = data;
        return r;
    endfunction

    // Handshakes come from registered state only, so in_ready has no
    // combinational path from any input.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;

    assign operator_1 = mainEntry.opnd1;
    assign operator_2 = mainEntry.opnd2;
    assign alu_op     = mainEntry.op;
    assign out_rd     = mainEntry.rd;
    assign out_rd_wen = mainEntry.rdWen;

    // Build the incoming entry: select operand sources and forward writeback.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        newEntry         = '0;
        newEntry.op      = in_op;
        newEntry.rd      = in_rd;
        newEntry.rdWen   = in_rd_wen;
        newEntry.src1Reg = !in_use_pc;
        newEntry.src1Idx = in_rs1_idx;
        newEntry.src2Reg = !in_use_imm;
        newEntry.src2Idx = in_rs2_idx;
        if (in_use_pc)
            newEntry.opnd1 = in_pc;
        else if (wbHit(1'b1, in_rs1_idx, wb_wen, wb_rd))
            newEntry.opnd1 = wb_data;
        else
            newEntry.opnd1 = in_rs1_data;
        if (in_use_imm)
            newEntry.opnd2 = in_imm;
        else if (wbHit(1'b1, in_rs2_idx, wb_wen, wb_rd))
            newEntry.opnd2 = wb_data;
        else
            newEntry.opnd2 = in_rs2_data;
        mainByp = applyBypass(mainEntry, wb_wen, wb_rd, wb_data);
        skidByp = applyBypass(skidEntry, wb_wen, wb_rd, wb_data);
    end

    // Next state and entry movement; held entries keep their bypassed values.
    always_comb begin
        stateNext = state;
        mainNext  = mainByp;
        skidNext  = skidByp;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inFire) begin
                        stateNext = ONE;
                        mainNext  = newEntry;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainNext = newEntry;
                    end else if (inFire) begin
                        stateNext = FULL;
                        skidNext  = newEntry;
                    end else if (outFire) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        stateNext = ONE;
                        mainNext  = skidByp;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // State and entry registers; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: both entries are reset because the main entry drives the outputs, which must read zero in reset.
        if (rst) begin
            state     <= EMPTY;
            mainEntry <= '0;
            skidEntry <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= stateNext;
            mainEntry <= mainNext;
            skidEntry <= skidNext;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed stimulus for alu_issue, checked every cycle against a
// queue model of the issue buffer, plus hand-computed literal expectations.
module tb_alu_issue;
    localparam int XLEN = 64;
    localparam int AOPW = 4;

    logic            clk, rst;
    logic            in_valid, in_ready;
    logic [AOPW-1:0] in_op;
    logic [4:0]      in_rd, in_rs1_idx, in_rs2_idx;
    logic            in_rd_wen;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic            in_use_imm, in_use_pc;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush, out_valid, out_ready;
    logic [XLEN-1:0] operator_1, operator_2;
    logic [AOPW-1:0] alu_op;
    logic [4:0]      out_rd;
    logic            out_rd_wen;

    alu_issue #(.XLEN(XLEN), .AOPW(AOPW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .operator_1(operator_1), .operator_2(operator_2), .alu_op(alu_op),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- queue model ----------------
    typedef struct {
        logic [AOPW-1:0] op;
        logic [4:0]      rd;
        logic            wen;
        logic [XLEN-1:0] v1, v2;
        bit              reg1, reg2;
        logic [4:0]      idx1, idx2;
    } inst_t;

    inst_t q[$];

    function automatic bit fwd(bit isReg, logic [4:0] idx);
        return isReg && (idx != 5'd0) && (wb_wen === 1'b1) && (wb_rd == idx);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            inst_t n;
            bit    acc, emit;
            acc  = in_valid && (q.size() < 2);
            emit = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[i]) begin
                    if (fwd(q[i].reg1, q[i].idx1)) q[i].v1 = wb_data;
                    if (fwd(q[i].reg2, q[i].idx2)) q[i].v2 = wb_data;
                end
                if (emit) void'(q.pop_front());
                if (acc) begin
                    n.op   = in_op;
                    n.rd   = in_rd;
                    n.wen  = in_rd_wen;
                    n.reg1 = !in_use_pc;
                    n.idx1 = in_rs1_idx;
                    n.reg2 = !in_use_imm;
                    n.idx2 = in_rs2_idx;
                    n.v1   = in_use_pc  ? in_pc  : (fwd(1'b1, in_rs1_idx) ? wb_data : in_rs1_data);
                    n.v2   = in_use_imm ? in_imm : (fwd(1'b1, in_rs2_idx) ? wb_data : in_rs2_data);
                    q.push_back(n);
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", XLEN'(out_valid), '0);
            check("rst_operator_1", operator_1, '0);
            check("rst_operator_2", operator_2, '0);
            check("rst_ctrl", XLEN'({alu_op, out_rd, out_rd_wen}), '0);
        end else begin
            check("in_ready", XLEN'(in_ready), XLEN'(q.size() < 2));
            check("out_valid", XLEN'(out_valid), XLEN'(q.size() > 0));
            if (q.size() > 0) begin
                check("operator_1", operator_1, q[0].v1);
                check("operator_2", operator_2, q[0].v2);
                check("ctrl", XLEN'({alu_op, out_rd, out_rd_wen}),
                      XLEN'({q[0].op, q[0].rd, q[0].wen}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        in_valid = 1'b0;
        wb_wen   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic offer(input logic [AOPW-1:0] op, input logic [4:0] rd,
                         input logic [4:0] r1i, input logic [XLEN-1:0] r1d,
                         input logic [4:0] r2i, input logic [XLEN-1:0] r2d,
                         input bit useImm, input logic [XLEN-1:0] imm,
                         input bit usePc, input logic [XLEN-1:0] pc);
        in_valid    = 1'b1;
        in_op       = op;
        in_rd       = rd;
        in_rd_wen   = 1'b1;
        in_rs1_idx  = r1i;
        in_rs1_data = r1d;
        in_rs2_idx  = r2i;
        in_rs2_data = r2d;
        in_use_imm  = useImm;
        in_imm      = imm;
        in_use_pc   = usePc;
        in_pc       = pc;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        wb_rd = '0; wb_data = '0;
        offer('0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
        in_valid = 1'b0;
        step(); step();
        check("reset_out_valid", XLEN'(out_valid), '0);
        check("reset_op1", operator_1, '0);
        rst = 1'b0;
        check("post_reset_in_ready", XLEN'(in_ready), 1);

        // single issue with immediate
        offer(4'd0, 5'd1, 5'd2, 64'd5, 5'd0, 64'd0, 1'b1, 64'd7, 1'b0, 64'd0);
        step(); idle();
        check("single_valid", XLEN'(out_valid), 1);
        check("single_op1", operator_1, 64'd5);
        check("single_op2", operator_2, 64'd7);
        step();
        check("single_drained", XLEN'(out_valid), 0);

        // pc as operand 1, register as operand 2
        offer(4'd5, 5'd6, 5'd0, 64'd0, 5'd7, 64'h1234, 1'b0, 64'd0, 1'b1, 64'h1000);
        step(); idle();
        check("pc_op1", operator_1, 64'h1000);
        check("pc_op2", operator_2, 64'h1234);
        check("pc_aluop", XLEN'(alu_op), 5);
        step();

        // backpressure: A, B accepted, C refused until space
        out_ready = 1'b0;
        offer(4'd1, 5'd1, 5'd0, 64'hA, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        check("bp_ready_one", XLEN'(in_ready), 1);
        offer(4'd2, 5'd2, 5'd0, 64'hB, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        check("bp_ready_full", XLEN'(in_ready), 0);
        offer(4'd3, 5'd3, 5'd0, 64'hC, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        check("bp_c_refused", XLEN'(in_ready), 0);
        check("bp_hold_a", operator_1, 64'hA);
        out_ready = 1'b1;
        step();
        check("bp_emit_b", operator_1, 64'hB);
        step(); idle();
        check("bp_emit_c", operator_1, 64'hC);
        check("bp_emit_c_op", XLEN'(alu_op), 3);
        step();
        check("bp_empty", XLEN'(out_valid), 0);

        // bypass at capture, nonzero index then index 0
        out_ready = 1'b0;
        offer(4'd4, 5'd4, 5'd3, 64'd1, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
        step(); idle();
        check("cap_bypass", operator_1, 64'h55);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        offer(4'd4, 5'd4, 5'd0, 64'd1, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
        step(); idle();
        check("cap_x0_no_bypass", operator_1, 64'd1);
        out_ready = 1'b1;
        step();

        // bypass while stalled in FULL
        out_ready = 1'b0;
        offer(4'd6, 5'd6, 5'd0, 64'd0, 5'd4, 64'd9, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        offer(4'd7, 5'd7, 5'd0, 64'd0, 5'd4, 64'd2, 1'b1, 64'h33, 1'b0, 64'd0);
        step(); idle();
        check("stall_before", operator_2, 64'd9);
        wb_wen = 1'b1; wb_rd = 5'd4; wb_data = 64'hAA;
        step();
        wb_wen = 1'b0;
        check("stall_bypass", operator_2, 64'hAA);
        out_ready = 1'b1;
        step();
        check("stall_imm_untouched", operator_2, 64'h33);
        check("stall_imm_op", XLEN'(alu_op), 7);
        step();

        // flush from FULL with a same-cycle offer
        out_ready = 1'b0;
        offer(4'd8, 5'd8, 5'd0, 64'h8, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        offer(4'd9, 5'd9, 5'd0, 64'h9, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        offer(4'd10, 5'd10, 5'd0, 64'h10, 5'd0, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0);
        flush = 1'b1;
        step(); idle();
        check("flush_valid", XLEN'(out_valid), 0);
        check("flush_ready", XLEN'(in_ready), 1);
        out_ready = 1'b1;
        step(); step(); step();
        check("flush_nothing_emitted", XLEN'(out_valid), 0);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        offer(4'd11, 5'd11, 5'd0, 64'h77, 5'd0, 64'd0, 1'b1, 64'h1, 1'b0, 64'd0);
        step();
        offer(4'd12, 5'd12, 5'd0, 64'h78, 5'd0, 64'd0, 1'b1, 64'h2, 1'b0, 64'd0);
        step(); idle();
        check("pre_reset_full", XLEN'(in_ready), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", XLEN'(out_valid), 0);
        check("async_op1", operator_1, '0);
        check("async_op2", operator_2, '0);
        check("async_ctrl", XLEN'({alu_op, out_rd, out_rd_wen}), '0);
        check("async_in_ready", XLEN'(in_ready), 1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        offer(4'd0, 5'd1, 5'd2, 64'd5, 5'd0, 64'd0, 1'b1, 64'd7, 1'b0, 64'd0);
        step(); idle();
        check("resume_valid", XLEN'(out_valid), 1);
        check("resume_op1", operator_1, 64'd5);
        step();
        check("resume_drained", XLEN'(out_valid), 0);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
